// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: buffers host register commands and issues them one at a time to the UART, returning checked responses
// Build option: define UART_CMD_SEQ_WR_ACK_EN to make successful writes return a response (data 0, err 00).
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   host_cmd, host_vld, host_rdy  host command push into the FIFO (rdy = not full)
//   uart_cmd, uart_cmd_vld/_rdy   command issue to the UART; uart_cmd is the FIFO head
//   uart_read_rdy, uart_read_data UART read return pulse; MSB is the odd-parity bit
//   rsp_vld, rsp_data, rsp_err    response to host (err 00 ok, 01 parity, 10 timeout)
//   rsp_rdy                       host accepts the response
//   fifo_level, busy              FIFO occupancy; sequencer active or FIFO non-empty
module uart_cmd_seq #(
   parameter int          DEPTH      = 4,
   parameter int          CMD_WIDTH  = 16,
   parameter int          READ_WIDTH = 8,
   parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [CMD_WIDTH-1:0]   host_cmd,
   input  logic                   host_vld,
   output logic                   host_rdy,
   output logic [CMD_WIDTH-1:0]   uart_cmd,
   output logic                   uart_cmd_vld,
   input  logic                   uart_cmd_rdy,
   input  logic                   uart_read_rdy,
   input  logic [READ_WIDTH:0]    uart_read_data,
   output logic                   rsp_vld,
   output logic [READ_WIDTH-1:0]  rsp_data,
   output logic [1:0]             rsp_err,
   input  logic                   rsp_rdy,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   busy
);
   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, WAIT_RD, RESP} state_t;
`ifdef UART_CMD_SEQ_WR_ACK_EN
   localparam state_t WR_DONE = RESP;
`else
   localparam state_t WR_DONE = IDLE;
`endif

   state_t                state_q, state_d;
   logic [CMD_WIDTH-1:0]  mem_q [DEPTH];
   logic [CMD_WIDTH-1:0]  mem_d [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]           level_q, level_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  rw_q, rw_d, cap_vld_q, cap_vld_d;
   logic [READ_WIDTH:0]   cap_q, cap_d;
   logic [READ_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [1:0]            rsp_err_q, rsp_err_d;
   logic                  push, pop, waiting, tmo, got_rd;
   logic [READ_WIDTH:0]   rd_word;

   assign push    = host_vld && host_rdy;
   assign pop     = uart_cmd_vld && uart_cmd_rdy;
   assign waiting = (state_q == WAIT_DONE) || (state_q == WAIT_RD);
   assign tmo     = waiting && (cnt_q + 16'd1 == TIMEOUT);
   // A read pulse arriving on the same cycle as frame completion counts as already latched
   assign got_rd  = cap_vld_q || (waiting && uart_read_rdy);
   assign rd_word = cap_vld_q ? cap_q : uart_read_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (level_q != '0) state_d = ISSUE;
         ISSUE:     if (uart_cmd_rdy) state_d = WAIT_DONE;
         WAIT_DONE: if (tmo) state_d = RESP;
                    else if (uart_cmd_rdy) state_d = !rw_q ? WR_DONE : got_rd ? RESP : WAIT_RD;
         WAIT_RD:   if (tmo || got_rd) state_d = RESP;
         RESP:      if (rsp_rdy) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      uart_cmd_vld = (state_q == ISSUE);
      rsp_vld      = (state_q == RESP);
      busy         = (state_q != IDLE) || (level_q != '0);
      host_rdy     = (level_q != FULL);
      fifo_level   = level_q;
      uart_cmd     = mem_q[rd_ptr_q];
      rsp_data     = rsp_data_q;
      rsp_err      = rsp_err_q;
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = host_cmd;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      level_d   = level_q + (AW+1)'(push) - (AW+1)'(pop);
      cnt_d     = waiting ? cnt_q + 16'd1 : 16'd0;
      rw_d      = pop ? uart_cmd[CMD_WIDTH-1] : rw_q;
      // Capture is cleared on issue so stray or late pulses never leak into the next command
      cap_vld_d = pop ? 1'b0 : got_rd;
      cap_d     = (waiting && uart_read_rdy && !cap_vld_q) ? uart_read_data : cap_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      if (state_d == RESP && state_q != RESP) begin
         rsp_data_d = (tmo || !rw_q) ? '0 : rd_word[READ_WIDTH-1:0];
         rsp_err_d  = tmo ? 2'b10 : (!rw_q || ^rd_word) ? 2'b00 : 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         cnt_q      <= '0;
         rw_q       <= 1'b0;
         cap_vld_q  <= 1'b0;
         cap_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         cnt_q      <= cnt_d;
         rw_q       <= rw_d;
         cap_vld_q  <= cap_vld_d;
         cap_q      <= cap_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end
endmodule

// File: tb/tb_uart_cmd_seq.sv
// tb_uart_cmd_seq: directed and randomized checks of uart_cmd_seq against a queue-based reference model
module tb_uart_cmd_seq;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [15:0] host_cmd = '0;
   logic        host_vld = 1'b0, host_rdy;
   logic [15:0] uart_cmd;
   logic        uart_cmd_vld, uart_cmd_rdy = 1'b0, uart_read_rdy = 1'b0;
   logic [8:0]  uart_read_data = '0;
   logic        rsp_vld, rsp_rdy = 1'b0, busy;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_err;
   logic [2:0]  fifo_level;

   int          checks = 0, errors = 0;
   logic [15:0] q[$];

   uart_cmd_seq #(.DEPTH(4), .CMD_WIDTH(16), .READ_WIDTH(8), .TIMEOUT(16'd100)) dut (
      .clk(clk), .rst_n(rst_n), .host_cmd(host_cmd), .host_vld(host_vld), .host_rdy(host_rdy),
      .uart_cmd(uart_cmd), .uart_cmd_vld(uart_cmd_vld), .uart_cmd_rdy(uart_cmd_rdy),
      .uart_read_rdy(uart_read_rdy), .uart_read_data(uart_read_data),
      .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_rdy(rsp_rdy),
      .fifo_level(fifo_level), .busy(busy));

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   // Expected {err, data} for a read return: an odd number of ones across all 9 bits is good
   function automatic logic [9:0] exp_read(input logic [8:0] w);
      return ($countones(w) % 2 == 1) ? {2'b00, w[7:0]} : {2'b01, w[7:0]};
   endfunction

   task automatic check_rsp(input string tag, input logic [9:0] e);
      chk({tag, "_vld"}, rsp_vld, 1);
      chk({tag, "_data"}, rsp_data, e[7:0]);
      chk({tag, "_err"}, rsp_err, e[9:8]);
   endtask

   task automatic handshake;
      chk("issue_vld", uart_cmd_vld, 1);
      chk("issue_cmd", uart_cmd, q[0]);
      uart_cmd_rdy = 1'b1; tick; uart_cmd_rdy = 1'b0;
      void'(q.pop_front());
      chk("issue_done", uart_cmd_vld, 0);
   endtask

   task automatic read_pulse(input logic [8:0] w);
      uart_read_rdy = 1'b1; uart_read_data = w; tick;
      uart_read_rdy = 1'b0; uart_read_data = '0;
   endtask

   task automatic serve_read(input logic [8:0] w, input bit rf, input int lat);
      repeat (lat) tick;
      if (rf) begin
         read_pulse(w);
         chk("rd_early_norsp", rsp_vld, 0);
         uart_cmd_rdy = 1'b1; tick; uart_cmd_rdy = 1'b0;
      end else begin
         uart_cmd_rdy = 1'b1; tick; uart_cmd_rdy = 1'b0;
         chk("wait_rd_norsp", rsp_vld, 0);
         repeat (lat % 5) tick;
         read_pulse(w);
      end
      check_rsp("rd", exp_read(w));
   endtask

   task automatic accept(input logic [9:0] e, input int hold);
      repeat (hold) begin
         tick;
         check_rsp("hold", e);
      end
      rsp_rdy = 1'b1; tick; rsp_rdy = 1'b0;
      chk("rsp_drop", rsp_vld, 0);
      chk("rsp_idle", busy, 0);
   endtask

   task automatic run_txn(input logic [15:0] c, input logic [8:0] w, input int lat, input bit rf, input int hold);
      host_cmd = c; host_vld = 1'b1; q.push_back(c); tick; host_vld = 1'b0;
      chk("push_lvl", fifo_level, 1);
      chk("push_vld", uart_cmd_vld, 0);
      uart_read_rdy = 1'b1; uart_read_data = ~w; tick;
      chk("issue_lat", uart_cmd_vld, 1);
      tick; uart_read_rdy = 1'b0; uart_read_data = '0;
      handshake;
      if (c[15]) begin
         serve_read(w, rf, lat);
         accept(exp_read(w), hold);
      end else begin
         repeat (lat) tick;
         uart_cmd_rdy = 1'b1; tick; uart_cmd_rdy = 1'b0;
`ifdef UART_CMD_SEQ_WR_ACK_EN
         check_rsp("wr_ack", 10'h000);
         accept(10'h000, hold);
`else
         chk("wr_norsp", rsp_vld, 0);
         chk("wr_idle", busy, 0);
`endif
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_host_rdy"}, host_rdy, 1);
      chk({tag, "_cmd_vld"}, uart_cmd_vld, 0);
      chk({tag, "_cmd"}, uart_cmd, 0);
      chk({tag, "_rsp_vld"}, rsp_vld, 0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
      chk({tag, "_level"}, fifo_level, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic timeout_txn(input logic [15:0] c);
      int k;
      host_cmd = c; host_vld = 1'b1; q.push_back(c); tick; host_vld = 1'b0; tick;
      handshake;
      k = 0;
      while (!rsp_vld && k < 200) begin
         tick; k++;
      end
      chk("tmo_cycles", k, 100);
      check_rsp("tmo", 10'h200);
      while (k < 150) begin
         tick; k++;
      end
      read_pulse(9'h15A);
      check_rsp("tmo_late", 10'h200);
      accept(10'h200, 0);
      repeat (3) tick;
      chk("tmo_after_vld", rsp_vld, 0);
      chk("tmo_after_busy", busy, 0);
   endtask

   initial begin
      logic [15:0] c;
      logic [8:0]  w;
      int          nissue, nrsp, nexp;
      repeat (3) tick;
      check_reset_vals("in_rst");
      rst_n = 1'b1;
      tick;
      check_reset_vals("post_rst");

      run_txn(16'h8A00, 9'h15A, 19, 1'b0, 2);
      run_txn(16'h8A00, 9'h05A, 19, 1'b0, 0);
      for (int n = 0; n < 12; n++) begin
         c = 16'($urandom);
         w = 9'($urandom);
         run_txn(c, w, $urandom_range(0, 60), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      for (int i = 0; i < 5; i++) begin
         host_cmd = 16'h0111 + 16'(i) * 16'h0011; host_vld = 1'b1;
         if (q.size() < 4) q.push_back(host_cmd);
         tick;
         chk("full_lvl", fifo_level, q.size());
         chk("full_rdy", host_rdy, q.size() != 4);
      end
      host_vld = 1'b0;
      uart_cmd_rdy = 1'b1; rsp_rdy = 1'b1;
      nissue = 0; nrsp = 0;
      for (int k = 0; k < 40; k++) begin
         if (uart_cmd_vld) begin
            nissue++;
            if (q.size() > 0) chk("drain_order", uart_cmd, q.pop_front());
         end
         if (rsp_vld) nrsp++;
         tick;
      end
      uart_cmd_rdy = 1'b0; rsp_rdy = 1'b0;
`ifdef UART_CMD_SEQ_WR_ACK_EN
      nexp = 4;
`else
      nexp = 0;
`endif
      chk("drain_issued", nissue, 4);
      chk("drain_rsps", nrsp, nexp);
      chk("drain_lvl", fifo_level, 0);
      chk("drain_busy", busy, 0);

      timeout_txn(16'h8123);
      timeout_txn(16'h0456);

      host_cmd = 16'h8AAA; host_vld = 1'b1; q.push_back(host_cmd); tick;
      host_cmd = 16'h8BBB; q.push_back(host_cmd); tick; host_vld = 1'b0;
      chk("bp_lvl", fifo_level, 2);
      handshake;
      serve_read(9'h1C3, 1'b0, 5);
      uart_cmd_rdy = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick;
         check_rsp("bp_hold", exp_read(9'h1C3));
         chk("bp_noissue", uart_cmd_vld, 0);
         chk("bp_lvl_hold", fifo_level, 1);
      end
      uart_cmd_rdy = 1'b0; rsp_rdy = 1'b1; tick; rsp_rdy = 1'b0;
      chk("bp_drop", rsp_vld, 0);
      tick;
      handshake;
      serve_read(9'h0F0, 1'b1, 3);
      accept(exp_read(9'h0F0), 0);

      host_cmd = 16'h8CCC; host_vld = 1'b1; q.push_back(host_cmd); tick;
      host_cmd = 16'h0777; q.push_back(host_cmd); tick; host_vld = 1'b0;
      handshake;
      uart_cmd_rdy = 1'b1; tick; uart_cmd_rdy = 1'b0;
      chk("mid_norsp", rsp_vld, 0);
      chk("mid_lvl", fifo_level, 1);
      chk("mid_busy", busy, 1);
      rst_n = 1'b0; #1;
      q.delete();
      check_reset_vals("mid_rst");
      tick; rst_n = 1'b1;
      read_pulse(9'h155);
      check_reset_vals("after_rst");
      run_txn(16'h0321, 9'h000, 4, 1'b0, 1);
      run_txn(16'h9001, 9'h1FF, 7, 1'b1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
